alu_share_arb: RTL

Two-requester arbiter that time-shares the single combinational 32-bit ALU between the execute stage (requester 0) and the address/auxiliary unit (requester 1). It grants one request per cycle and drives the ALU operands and control. It captures the result and NZCV flags into a one-entry response register with valid/ready backpressure. It also holds the architectural NZCV flags register, written only by requests that set flags.

---
 rtl/alu_share_arb_if.sv | 34 +++
 rtl/alu_share_arb.sv | 112 +++++++++++
 2 files changed

// File: rtl/alu_share_arb_if.sv
// Request, shared-ALU and response bundle for alu_share_arb.
// slave = arbiter side; master = requesters, ALU and response consumer.
interface alu_share_arb_if;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_rn, req1_rn;
    logic [31:0] req0_src2, req1_src2;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        req0_setflags, req1_setflags;
    logic [31:0] alu_rn, alu_src2;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_rd;
    logic [3:0]  alu_flags;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_rd;
    logic [3:0]  rsp_flags;
    logic [3:0]  flags;

    modport slave (
        input  req0_valid, req1_valid, req0_rn, req1_rn, req0_src2, req1_src2,
               req0_ctrl, req1_ctrl, req0_setflags, req1_setflags,
               alu_rd, alu_flags, rsp_ready,
        output req0_ready, req1_ready, alu_rn, alu_src2, alu_ctrl,
               rsp_valid, rsp_id, rsp_rd, rsp_flags, flags
    );

    modport master (
        output req0_valid, req1_valid, req0_rn, req1_rn, req0_src2, req1_src2,
               req0_ctrl, req1_ctrl, req0_setflags, req1_setflags,
               alu_rd, alu_flags, rsp_ready,
        input  req0_ready, req1_ready, alu_rn, alu_src2, alu_ctrl,
               rsp_valid, rsp_id, rsp_rd, rsp_flags, flags
    );
endinterface

// File: rtl/alu_share_arb.sv
// Two-requester arbiter for one shared combinational ALU, with a one-entry response
// register and the architectural NZCV register. ALU_ARB_FIXED_PRIO_EN: requester 0 always wins.
module alu_share_arb (
    input  logic           clk,
    input  logic           reset,
    alu_share_arb_if.slave bus
);
    logic [1:0]  req_vld, gnt;
    logic        avail, acc, gnt_id, gnt_setflags;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_rd_q, rsp_rd_d;
    logic [3:0]  rsp_flags_q, rsp_flags_d;
    logic [3:0]  flags_q, flags_d;

    assign req_vld = {bus.req1_valid, bus.req0_valid};
    assign avail   = ~rsp_valid_q | bus.rsp_ready;
    assign acc     = |gnt;
    assign gnt_id  = gnt[1];

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt = 2'b00;
        if (avail && !reset) begin
            if (req_vld[0])      gnt = 2'b01;
            else if (req_vld[1]) gnt = 2'b10;
        end
    end
`else
    logic last_id_q, last_id_d;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        gnt = 2'b00;
        if (avail && !reset) begin
            if (&req_vld) gnt = last_id_q ? 2'b01 : 2'b10;
            else          gnt = req_vld;
        end
    end

    always_comb begin
        last_id_d = last_id_q;
        if (acc) last_id_d = gnt_id;
    end

    always_ff @(posedge clk) begin
        if (reset) last_id_q <= 1'b1;
        else       last_id_q <= last_id_d;
    end
`endif

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];

    always_comb begin
        bus.alu_rn   = 32'h0;
        bus.alu_src2 = 32'h0;
        bus.alu_ctrl = 4'h0;
        gnt_setflags = 1'b0;
        if (gnt[0]) begin
            bus.alu_rn   = bus.req0_rn;
            bus.alu_src2 = bus.req0_src2;
            bus.alu_ctrl = bus.req0_ctrl;
            gnt_setflags = bus.req0_setflags;
        end else if (gnt[1]) begin
            bus.alu_rn   = bus.req1_rn;
            bus.alu_src2 = bus.req1_src2;
            bus.alu_ctrl = bus.req1_ctrl;
            gnt_setflags = bus.req1_setflags;
        end
    end

    // A new acceptance always overwrites, so drain+accept keeps rsp_valid high.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_rd_d    = rsp_rd_q;
        rsp_flags_d = rsp_flags_q;
        flags_d     = flags_q;
        if (acc) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gnt_id;
            rsp_rd_d    = bus.alu_rd;
            rsp_flags_d = bus.alu_flags;
            if (gnt_setflags) flags_d = bus.alu_flags;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_rd_q    <= 32'h0;
            rsp_flags_q <= 4'h0;
            flags_q     <= 4'h0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_flags_q <= rsp_flags_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_rd    = rsp_rd_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.flags     = flags_q;
endmodule
